// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch: 1 Hz counting, 2 Hz field adjust, pause toggle,
// clear, and blink qualifiers for the display driver.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   tick_1hz, tick_2hz    single-cycle enable ticks from the divider
//   rst, pause, sel, adj  debounced button levels
//   min_t, min_o          minutes tens/ones (BCD)
//   sec_t, sec_o          seconds tens/ones (BCD)
//   paused                counting halted in normal mode
//   blink_min, blink_sec  blank the selected field while adjusting
module stopwatch_core #(
  parameter int MAX_TENS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       rst,
  input  logic       pause,
  input  logic       sel,
  input  logic       adj,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       paused,
  output logic       blink_min,
  output logic       blink_sec
);

  localparam logic [3:0] TMAX = MAX_TENS[3:0];

  logic [3:0] min_t_q, min_t_d;
  logic [3:0] min_o_q, min_o_d;
  logic [3:0] sec_t_q, sec_t_d;
  logic [3:0] sec_o_q, sec_o_d;
  logic       paused_q, paused_d;
  logic       pause_q, pause_d;
  logic       blink_phase_q, blink_phase_d;
  logic       blink_min_q, blink_min_d;
  logic       blink_sec_q, blink_sec_d;

  logic       pause_edge;
  logic [8:0] sec_inc;
  logic [8:0] min_inc;

  // Returns {carry, tens, ones} for a 00..(TMAX)9 field.
  function automatic logic [8:0] inc_field(
    input logic [3:0] t,
    input logic [3:0] o
  );
    logic [8:0] r;
    if (o != 4'd9) begin
      r = {1'b0, t, o + 4'd1};
    end else if (t != TMAX) begin
      r = {1'b0, t + 4'd1, 4'd0};
    end else begin
      r = {1'b1, 8'd0};
    end
    return r;
  endfunction

  always_comb begin
    sec_inc = inc_field(sec_t_q, sec_o_q);
    min_inc = inc_field(min_t_q, min_o_q);

    min_t_d = min_t_q;
    min_o_d = min_o_q;
    sec_t_d = sec_t_q;
    sec_o_d = sec_o_q;

    pause_d    = pause;
    pause_edge = pause & ~pause_q;

    unique case (1'b1)
      rst: begin
        min_t_d = 4'd0;
        min_o_d = 4'd0;
        sec_t_d = 4'd0;
        sec_o_d = 4'd0;
      end
      (!rst && adj): begin
        // Each field wraps on its own; no carry between them.
        if (tick_2hz) begin
          if (sel) begin
            sec_t_d = sec_inc[7:4];
            sec_o_d = sec_inc[3:0];
          end else begin
            min_t_d = min_inc[7:4];
            min_o_d = min_inc[3:0];
          end
        end
      end
      (!rst && !adj): begin
        // Gate with the pre-toggle paused value.
        if (tick_1hz && !paused_q) begin
          sec_t_d = sec_inc[7:4];
          sec_o_d = sec_inc[3:0];
          if (sec_inc[8]) begin
            min_t_d = min_inc[7:4];
            min_o_d = min_inc[3:0];
          end
        end
      end
      default: ;
    endcase

    paused_d      = paused_q ^ pause_edge;
    blink_phase_d = blink_phase_q ^ tick_2hz;
    blink_min_d   = adj & ~rst & ~sel & blink_phase_d;
    blink_sec_d   = adj & ~rst & sel & blink_phase_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_t_q       <= 4'd0;
      min_o_q       <= 4'd0;
      sec_t_q       <= 4'd0;
      sec_o_q       <= 4'd0;
      paused_q      <= 1'b0;
      pause_q       <= 1'b0;
      blink_phase_q <= 1'b0;
      blink_min_q   <= 1'b0;
      blink_sec_q   <= 1'b0;
    end else begin
      min_t_q       <= min_t_d;
      min_o_q       <= min_o_d;
      sec_t_q       <= sec_t_d;
      sec_o_q       <= sec_o_d;
      paused_q      <= paused_d;
      pause_q       <= pause_d;
      blink_phase_q <= blink_phase_d;
      blink_min_q   <= blink_min_d;
      blink_sec_q   <= blink_sec_d;
    end
  end

  assign min_t     = min_t_q;
  assign min_o     = min_o_q;
  assign sec_t     = sec_t_q;
  assign sec_o     = sec_o_q;
  assign paused    = paused_q;
  assign blink_min = blink_min_q;
  assign blink_sec = blink_sec_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with a scoreboard queue.
// Expected state is pushed when a cycle is driven, popped after the edge.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_1hz = 1'b0;
  logic tick_2hz = 1'b0;
  logic rst = 1'b0;
  logic pause = 1'b0;
  logic sel = 1'b0;
  logic adj = 1'b0;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic paused, blink_min, blink_sec;
  logic [15:0] dig_o;

  always #5 clk = ~clk;

  stopwatch_core #(.MAX_TENS(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick_1hz(tick_1hz),
    .tick_2hz(tick_2hz),
    .rst(rst),
    .pause(pause),
    .sel(sel),
    .adj(adj),
    .min_t(min_t),
    .min_o(min_o),
    .sec_t(sec_t),
    .sec_o(sec_o),
    .paused(paused),
    .blink_min(blink_min),
    .blink_sec(blink_sec)
  );

  assign dig_o = {min_t, min_o, sec_t, sec_o};

  typedef struct {
    string       tag;
    logic [15:0] dig;
    logic        pz;
    logic        bm;
    logic        bs;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  int m_min = 0;
  int m_sec = 0;
  bit m_paused = 0;
  bit m_pq = 0;
  bit m_phase = 0;
  bit m_bm = 0;
  bit m_bs = 0;

  function automatic logic [15:0] bcd(int mm, int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic push(string tag);
    exp_t e;
    e.tag = tag;
    e.dig = bcd(m_min, m_sec);
    e.pz  = m_paused;
    e.bm  = m_bm;
    e.bs  = m_bs;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e = sb.pop_front();
    n_checks++;
    assert (dig_o === e.dig) else begin
      n_errors++;
      $error("FAIL %s digits observed=%h expected=%h", e.tag, dig_o, e.dig);
    end
    n_checks++;
    assert (paused === e.pz) else begin
      n_errors++;
      $error("FAIL %s paused observed=%b expected=%b", e.tag, paused, e.pz);
    end
    n_checks++;
    assert (blink_min === e.bm) else begin
      n_errors++;
      $error("FAIL %s blink_min observed=%b expected=%b",
             e.tag, blink_min, e.bm);
    end
    n_checks++;
    assert (blink_sec === e.bs) else begin
      n_errors++;
      $error("FAIL %s blink_sec observed=%b expected=%b",
             e.tag, blink_sec, e.bs);
    end
  endtask

  // One clock cycle: drive, advance model, push, clock, compare.
  task automatic cyc(string tag, bit t1, bit t2, bit r, bit p,
                     bit s, bit a);
    bit edge_p;
    tick_1hz = t1;
    tick_2hz = t2;
    rst      = r;
    pause    = p;
    sel      = s;
    adj      = a;
    edge_p = p & ~m_pq;
    m_pq   = p;
    if (r) begin
      m_min = 0;
      m_sec = 0;
    end else if (a) begin
      if (t2) begin
        if (s) m_sec = (m_sec + 1) % 60;
        else   m_min = (m_min + 1) % 60;
      end
    end else if (t1 && !m_paused) begin
      m_sec = m_sec + 1;
      if (m_sec == 60) begin
        m_sec = 0;
        m_min = (m_min + 1) % 60;
      end
    end
    if (edge_p) m_paused = ~m_paused;
    if (t2) m_phase = ~m_phase;
    m_bm = a & ~r & ~s & m_phase;
    m_bs = a & ~r & s & m_phase;
    push(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic set_time(int mm, int ss);
    int nm, ns;
    nm = (mm - m_min + 60) % 60;
    ns = (ss - m_sec + 60) % 60;
    for (int i = 0; i < nm; i++) cyc("set_min", 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < ns; i++) cyc("set_sec", 0, 1, 0, 0, 1, 1);
    cyc("set_done", 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick1(string tag, int n);
    for (int i = 0; i < n; i++) cyc(tag, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    push("por");
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    // Run to 12:34, then async reset mid-count.
    set_time(12, 33);
    tick1("to_1234", 1);
    cyc("tick2_ignored", 0, 1, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    m_min = 0; m_sec = 0; m_paused = 0; m_pq = 0;
    m_phase = 0; m_bm = 0; m_bs = 0;
    push("async_rst");
    #2;
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    tick1("after_rst", 3);

    // Pause behaviour.
    tick1("to_0005", 2);
    cyc("pause_rise", 0, 0, 0, 1, 0, 0);
    cyc("pause_fall", 0, 0, 0, 0, 0, 0);
    tick1("paused_hold", 5);
    cyc("unpause", 0, 0, 0, 1, 0, 0);
    cyc("unpause_fall", 0, 0, 0, 0, 0, 0);
    tick1("to_0006", 1);
    // Tick coinciding with the pause edge uses pre-toggle state.
    cyc("tick_on_pause", 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 1000; i++)
      cyc("pause_held", (i % 100) == 7, 0, 0, 1, 0, 0);
    cyc("held_release", 0, 0, 0, 0, 0, 0);
    cyc("resume", 0, 0, 0, 1, 0, 0);
    cyc("resume_fall", 0, 0, 0, 0, 0, 0);

    // Rollover.
    set_time(59, 58);
    tick1("roll_5959", 1);
    tick1("roll_0000", 1);
    set_time(9, 59);
    tick1("roll_1000", 1);

    // Adjust minutes with no carry; 1 Hz ignored.
    set_time(58, 30);
    cyc("adj_min_a", 0, 1, 0, 0, 0, 1);
    cyc("adj_min_b", 0, 1, 0, 0, 0, 1);
    cyc("adj_min_c", 0, 1, 0, 0, 0, 1);
    cyc("adj_t1_ign", 1, 0, 0, 0, 0, 1);
    cyc("adj_idle", 0, 0, 0, 0, 0, 1);
    cyc("adj_min_d", 0, 1, 0, 0, 0, 1);
    tick1("adj_exit", 1);

    // Adjust seconds while paused.
    set_time(0, 59);
    cyc("pz_rise", 0, 0, 0, 1, 0, 0);
    cyc("pz_fall", 0, 0, 0, 0, 0, 0);
    cyc("adj_sec_wrap", 0, 1, 0, 0, 1, 1);
    cyc("adj_sec_more", 0, 1, 0, 0, 1, 1);
    tick1("paused_normal", 2);
    cyc("pz_edge_adj", 0, 0, 0, 1, 1, 1);
    cyc("pz_fall2", 0, 0, 0, 0, 0, 0);

    // Clear priority over adjust.
    set_time(23, 45);
    cyc("clr_adj", 0, 1, 1, 0, 0, 1);
    cyc("clr_hold", 1, 1, 1, 0, 1, 1);
    cyc("clr_pause", 0, 0, 1, 1, 0, 0);
    cyc("clr_exit", 0, 1, 0, 0, 0, 1);
    cyc("clr_exit_s", 0, 1, 0, 0, 1, 1);
    cyc("pz_final", 0, 0, 0, 0, 0, 0);
    tick1("normal_end", 3);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Consumer of the debounced button levels (`rst`, `pause`, `sel`, `adj`) produced by the button-conditioning stage. Maintains an MM:SS stopwatch in BCD, advanced by a 1 Hz enable tick in normal mode, or field-wise by a 2 Hz tick in adjust mode. Drives the four BCD digits and blink qualifiers consumed by the seven-segment display driver. Single clock domain; the divider supplies the tick enables.

## Interface
- `MAX_TENS`, default 5: highest tens digit for both minutes and seconds (field range 00–59).
- `clk`, input, 1: system clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `tick_1hz`, input, 1: single-cycle enable pulse at 1 Hz.
- `tick_2hz`, input, 1: single-cycle enable pulse at 2 Hz.
- `rst`, input, 1: debounced level, active-high; synchronous clear of time.
- `pause`, input, 1: debounced level; each rising edge toggles run/pause.
- `sel`, input, 1: debounced level; 0 = minutes field, 1 = seconds field.
- `adj`, input, 1: debounced level; 1 = adjust mode.
- `min_t`, output, 4: minutes tens digit (BCD).
- `min_o`, output, 4: minutes ones digit (BCD).
- `sec_t`, output, 4: seconds tens digit (BCD).
- `sec_o`, output, 4: seconds ones digit (BCD).
- `paused`, output, 1: 1 = counting halted in normal mode.
- `blink_min`, output, 1: blank minutes digits when high.
- `blink_sec`, output, 1: blank seconds digits when high.

## Operation
- All inputs are synchronous to `clk`. All outputs are registered.
- Pause detection:
  - `pause_q` holds `pause` delayed by one cycle; it resets to 0.
  - A rising edge is `pause & ~pause_q`. It toggles `paused` in every mode, including while `rst` or `adj` is high.
- Modes are decoded each cycle. Priority: `rst` > `adj` > normal.
  - CLEAR (`rst`=1): all digits forced to 0 every cycle. Ticks are ignored. `paused` is unaffected except by a pause edge.
  - ADJUST (`adj`=1, `rst`=0):
    - On `tick_2hz`, increment only the selected field: minutes when `sel`=0, seconds when `sel`=1.
    - Field wraps 59→00 with no carry into the other field.
    - `tick_1hz` is ignored. `paused` does not inhibit adjustment.
  - NORMAL (`adj`=0, `rst`=0):
    - On `tick_1hz` with `paused`=0, increment seconds.
    - sec_o 9→0 carries into sec_t. sec_t `MAX_TENS`→0 with sec_o 9 carries into minutes.
    - Minutes roll over the same way. 59:59 → 00:00.
    - `tick_2hz` is ignored.
- Blink:
  - `blink_phase` toggles on every `tick_2hz` in all modes; it resets to 0.
  - `blink_min` = `adj & ~rst & ~sel & blink_phase`.
  - `blink_sec` = `adj & ~rst & sel & blink_phase`.
  - Both are registered.
- Digit arithmetic: each digit is held 0–9 (tens 0–`MAX_TENS`). Out-of-range values never occur. The increment logic compares against 9 and `MAX_TENS` only.

## Timing
- Reset (`rst_n`=0, async): all digits 0, `paused`=0 (running), `pause_q`=0, `blink_phase`=0, `blink_min`=0, `blink_sec`=0.
- Release of `rst_n` is synchronised externally. The first active edge after release is a normal cycle.
- `pause` high at the first edge after reset counts as a rising edge (`pause_q` resets to 0) and toggles `paused`.
- Latency:
  - Tick sampled high at edge N → digits updated at edge N; visible after edge N.
  - `pause` rises before edge N → `paused` flips at edge N.
  - A `tick_1hz` coinciding with that edge is gated by the pre-toggle `paused` value.
- `rst` asserted: digits read 0 after the first edge it is sampled. A tick in the same cycle is discarded.
- `adj` or `sel` change takes effect at the next tick. No tick is carried over or queued.
- `adj` deasserted mid-field: adjusted value is kept and normal counting resumes from it on the next `tick_1hz`.
- `rst_n` asserted mid-count: immediate async clear; no partial carry is retained.

## Test plan
- Reset: assert `rst_n`=0 mid-run with time 12:34 → all outputs 0 immediately. After release, 3 `tick_1hz` → 00:03.
- Rollover: preload to 59:58 via adjust, then normal mode, 2 `tick_1hz` → 59:59, then 00:00. Also check 09:59 → 10:00.
- Pause:
  - At 00:05, pulse `pause` → `paused`=1. 5 `tick_1hz` → still 00:05.
  - Second `pause` rising edge → `paused`=0. Next tick → 00:06.
  - Holding `pause` high for 1000 cycles toggles only once.
- Adjust minutes: `adj`=1, `sel`=0, time 58:30. 3 `tick_2hz` → 59:30, 00:30, 01:30 (no carry). `tick_1hz` ignored. `blink_min` toggles per `tick_2hz`; `blink_sec`=0.
- Adjust seconds while paused: `paused`=1, `adj`=1, `sel`=1 at 00:59. One `tick_2hz` → 00:00, minutes unchanged.
- Clear priority: `rst`=1 together with `adj`=1 and a simultaneous `tick_2hz` → 00:00, both blinks 0. After `rst`=0 the adjust tick resumes from 00:00.
